// File: rtl/mtm_alu_deser_param_if.sv
// rtl/mtm_alu_deser_param_if.sv - serial input and parallel packet outputs of the ALU deserializer
interface mtm_alu_deser_param_if #(
    parameter int OPERAND_W = 32
);
    logic                 sin;
    logic [OPERAND_W-1:0] a_out;
    logic [OPERAND_W-1:0] b_out;
    logic [7:0]           ctl_out;
    logic                 out_valid;
    logic                 err_data;
    logic                 err_frame;
    logic                 busy;

    modport master (
        input  sin,
        output a_out, b_out, ctl_out, out_valid, err_data, err_frame, busy
    );

    modport slave (
        output sin,
        input  a_out, b_out, ctl_out, out_valid, err_data, err_frame, busy
    );
endinterface

// File: rtl/mtm_alu_deser_param.sv
// rtl/mtm_alu_deser_param.sv - 11-bit frame deserializer assembling two operands and a control byte
module mtm_alu_deser_param #(
    parameter int OPERAND_W = 32,
    parameter int GAP_MAX   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    mtm_alu_deser_param_if.master bus
);
    localparam int NB  = 2 * OPERAND_W / 8;
    localparam int BCW = $clog2(NB + 1);
    localparam int GCW = $clog2(GAP_MAX + 1);
    localparam logic [BCW-1:0] NB_C     = BCW'(NB);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_MAX - 1);

    typedef enum logic [2:0] {IDLE, TYPE, DATA, STOP, RECOVER} state_t;

    state_t                 state, state_nx;
    logic [2:0]             bit_cnt, bit_cnt_nx;
    logic                   is_ctl, is_ctl_nx;
    logic [7:0]             shift, shift_nx;
    logic [BCW-1:0]         byte_cnt, byte_cnt_nx;
    logic [GCW-1:0]         gap_cnt, gap_cnt_nx;
    logic                   overflow, overflow_nx;
    logic [2*OPERAND_W-1:0] data_sr, data_sr_nx;
    logic [OPERAND_W-1:0]   a_q, a_nx, b_q, b_nx;
    logic [7:0]             ctl_q, ctl_nx;
    logic                   valid_q, valid_nx;
    logic                   err_data_q, err_data_nx;
    logic                   err_frame_q, err_frame_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            is_ctl      <= 1'b0;
            shift       <= '0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            overflow    <= 1'b0;
            data_sr     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ctl_q       <= '0;
            valid_q     <= 1'b0;
            err_data_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            is_ctl      <= is_ctl_nx;
            shift       <= shift_nx;
            byte_cnt    <= byte_cnt_nx;
            gap_cnt     <= gap_cnt_nx;
            overflow    <= overflow_nx;
            data_sr     <= data_sr_nx;
            a_q         <= a_nx;
            b_q         <= b_nx;
            ctl_q       <= ctl_nx;
            valid_q     <= valid_nx;
            err_data_q  <= err_data_nx;
            err_frame_q <= err_frame_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        is_ctl_nx    = is_ctl;
        shift_nx     = shift;
        byte_cnt_nx  = byte_cnt;
        gap_cnt_nx   = gap_cnt;
        overflow_nx  = overflow;
        data_sr_nx   = data_sr;
        a_nx         = a_q;
        b_nx         = b_q;
        ctl_nx       = ctl_q;
        valid_nx     = 1'b0;
        err_data_nx  = 1'b0;
        err_frame_nx = 1'b0;

        case (state)
            IDLE: begin
                if (!bus.sin) begin
                    state_nx = TYPE;
                end else if (byte_cnt != '0) begin
                    // Idle gap inside a packet: the GAP_MAX-th idle clk drops the partial packet
                    if (gap_cnt == GAP_LAST) begin
                        err_data_nx = 1'b1;
                        byte_cnt_nx = '0;
                        gap_cnt_nx  = '0;
                        overflow_nx = 1'b0;
                    end else begin
                        gap_cnt_nx = gap_cnt + GCW'(1);
                    end
                end
            end
            TYPE: begin
                is_ctl_nx  = bus.sin;
                bit_cnt_nx = '0;
                state_nx   = DATA;
            end
            DATA: begin
                shift_nx   = {shift[6:0], bus.sin};
                bit_cnt_nx = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_nx = STOP;
            end
            STOP: begin
                gap_cnt_nx = '0;
                if (bus.sin) begin
                    state_nx = IDLE;
                    if (!is_ctl) begin
                        if (byte_cnt < NB_C) begin
                            data_sr_nx  = {data_sr[2*OPERAND_W-9:0], shift};
                            byte_cnt_nx = byte_cnt + BCW'(1);
                        end else begin
                            overflow_nx = 1'b1;
                        end
                    end else begin
                        if (byte_cnt == NB_C && !overflow) begin
                            // B arrived first, so it sits in the upper half of the shift register
                            b_nx     = data_sr[2*OPERAND_W-1:OPERAND_W];
                            a_nx     = data_sr[OPERAND_W-1:0];
                            ctl_nx   = shift;
                            valid_nx = 1'b1;
                        end else begin
                            err_data_nx = 1'b1;
                        end
                        byte_cnt_nx = '0;
                        overflow_nx = 1'b0;
                    end
                end else begin
                    err_frame_nx = 1'b1;
                    byte_cnt_nx  = '0;
                    overflow_nx  = 1'b0;
                    state_nx     = RECOVER;
                end
            end
            RECOVER: begin
                if (bus.sin) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.ctl_out   = ctl_q;
    assign bus.out_valid = valid_q;
    assign bus.err_data  = err_data_q;
    assign bus.err_frame = err_frame_q;
    assign bus.busy      = (state != IDLE) || (byte_cnt != '0);
endmodule

// File: tb/tb_mtm_alu_deser_param.sv
// tb/tb_mtm_alu_deser_param.sv - randomized packet-level checks of mtm_alu_deser_param at 32- and 16-bit widths
module tb_mtm_alu_deser_param;
    localparam int GAP = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mtm_alu_deser_param_if #(.OPERAND_W(32)) bus32();
    mtm_alu_deser_param_if #(.OPERAND_W(16)) bus16();

    mtm_alu_deser_param #(.OPERAND_W(32), .GAP_MAX(GAP)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    mtm_alu_deser_param #(.OPERAND_W(16), .GAP_MAX(GAP)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping: index 0 is the 32-bit unit, 1 the 16-bit unit; edges are posedge indices
    int n_valid[2]    = '{0, 0};
    int n_errd[2]     = '{0, 0};
    int n_errf[2]     = '{0, 0};
    int last_valid[2] = '{-1, -1};
    int last_errd[2]  = '{-1, -1};
    int last_errf[2]  = '{-1, -1};
    int excl_bad      = 0;

    always @(negedge clk) begin
        if (bus32.out_valid) begin n_valid[0]++; last_valid[0] = cyc - 1; end
        if (bus32.err_data)  begin n_errd[0]++;  last_errd[0]  = cyc - 1; end
        if (bus32.err_frame) begin n_errf[0]++;  last_errf[0]  = cyc - 1; end
        if (bus16.out_valid) begin n_valid[1]++; last_valid[1] = cyc - 1; end
        if (bus16.err_data)  begin n_errd[1]++;  last_errd[1]  = cyc - 1; end
        if (bus16.err_frame) begin n_errf[1]++;  last_errf[1]  = cyc - 1; end
        if (int'(bus32.out_valid) + int'(bus32.err_data) + int'(bus32.err_frame) > 1) excl_bad++;
        if (int'(bus16.out_valid) + int'(bus16.err_data) + int'(bus16.err_frame) > 1) excl_bad++;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0]  pkt_bytes[$];
    logic [63:0] exp_a[2] = '{64'd0, 64'd0};
    logic [63:0] exp_b[2] = '{64'd0, 64'd0};
    logic [63:0] exp_c[2] = '{64'd0, 64'd0};

    function automatic logic [63:0] out_a(input int sel);
        return (sel == 0) ? 64'(bus32.a_out) : 64'(bus16.a_out);
    endfunction
    function automatic logic [63:0] out_b(input int sel);
        return (sel == 0) ? 64'(bus32.b_out) : 64'(bus16.b_out);
    endfunction
    function automatic logic [63:0] out_c(input int sel);
        return (sel == 0) ? 64'(bus32.ctl_out) : 64'(bus16.ctl_out);
    endfunction
    function automatic logic [63:0] out_busy(input int sel);
        return (sel == 0) ? 64'(bus32.busy) : 64'(bus16.busy);
    endfunction

    // Bytes arrive MSB-byte first, so an operand is the big-endian number formed by its bytes
    function automatic logic [63:0] model_word(input int first, input int n);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(pkt_bytes[first + i]);
        return v;
    endfunction

    task automatic drive(input int sel, input logic b);
        if (sel == 0) bus32.sin = b;
        else          bus16.sin = b;
    endtask

    task automatic send_bit(input int sel, input logic b, output int edge_idx);
        @(negedge clk);
        edge_idx = cyc;
        drive(sel, b);
    endtask

    task automatic idle(input int sel, input int n);
        int e;
        for (int i = 0; i < n; i++) send_bit(sel, 1'b1, e);
    endtask

    task automatic send_frame(input int sel, input logic typ, input logic [7:0] payload,
                              input logic stop, output int start_edge, output int stop_edge);
        int e;
        send_bit(sel, 1'b0, start_edge);
        send_bit(sel, typ, e);
        for (int i = 7; i >= 0; i--) send_bit(sel, payload[i], e);
        send_bit(sel, stop, stop_edge);
    endtask

    task automatic fill_random(input int n);
        pkt_bytes.delete();
        for (int i = 0; i < n; i++) pkt_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    // Sends pkt_bytes as data frames then one ctl frame; gap < 0 picks a random short gap per frame
    task automatic run_packet(input int sel, input int gap, input logic [7:0] ctl, input string tag);
        int nbw = (sel == 0) ? 4 : 2;
        int k, s;
        int v0 = n_valid[sel];
        int d0 = n_errd[sel];
        int f0 = n_errf[sel];
        bit ok = (pkt_bytes.size() == 2 * nbw);
        for (int i = 0; i < pkt_bytes.size(); i++) begin
            send_frame(sel, 1'b0, pkt_bytes[i], 1'b1, k, s);
            idle(sel, (gap < 0) ? int'($urandom_range(0, 3)) : gap);
        end
        send_frame(sel, 1'b1, ctl, 1'b1, k, s);
        idle(sel, 2);
        #1;
        if (ok) begin
            exp_b[sel] = model_word(0, nbw);
            exp_a[sel] = model_word(nbw, nbw);
            exp_c[sel] = 64'(ctl);
        end
        check({tag, ".valid_cnt"}, 64'(n_valid[sel] - v0), ok ? 64'd1 : 64'd0);
        check({tag, ".errd_cnt"},  64'(n_errd[sel] - d0),  ok ? 64'd0 : 64'd1);
        check({tag, ".errf_cnt"},  64'(n_errf[sel] - f0),  64'd0);
        if (ok) check({tag, ".valid_edge"}, 64'(last_valid[sel]), 64'(k + 10));
        else    check({tag, ".errd_edge"},  64'(last_errd[sel]),  64'(k + 10));
        check({tag, ".a"},    out_a(sel), exp_a[sel]);
        check({tag, ".b"},    out_b(sel), exp_b[sel]);
        check({tag, ".ctl"},  out_c(sel), exp_c[sel]);
        check({tag, ".busy"}, out_busy(sel), 64'd0);
    endtask

    initial begin
        int k, s, v0, d0, f0;
        rst = 1'b1;
        bus32.sin = 1'b1;
        bus16.sin = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst.a", out_a(0), 64'd0);
        check("rst.b", out_b(0), 64'd0);
        check("rst.ctl", out_c(0), 64'd0);
        check("rst.pulses", 64'({bus32.out_valid, bus32.err_data, bus32.err_frame}), 64'd0);
        check("rst.busy", out_busy(0), 64'd0);
        rst = 1'b0;

        pkt_bytes = '{8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78};
        run_packet(0, 0, 8'h55, "t1");
        check("t1.a_const", out_a(0), 64'h1234_5678);
        check("t1.b_const", out_b(0), 64'h9ABC_DEF0);

        for (int i = 0; i < 5; i++) begin
            fill_random(8);
            run_packet(0, -1, 8'($urandom), "rnd32");
        end

        pkt_bytes.delete();
        run_packet(0, 0, 8'($urandom), "ctl_only");

        fill_random(7);
        run_packet(0, -1, 8'($urandom), "t2_short");
        fill_random(8);
        run_packet(0, -1, 8'($urandom), "t2_after");

        // Bad stop bit on the third data frame, then the line held low
        v0 = n_valid[0]; d0 = n_errd[0]; f0 = n_errf[0];
        fill_random(3);
        send_frame(0, 1'b0, pkt_bytes[0], 1'b1, k, s);
        send_frame(0, 1'b0, pkt_bytes[1], 1'b1, k, s);
        send_frame(0, 1'b0, pkt_bytes[2], 1'b0, k, s);
        for (int i = 0; i < 5; i++) send_bit(0, 1'b0, k);
        #1;
        check("t3.errf_cnt", 64'(n_errf[0] - f0), 64'd1);
        check("t3.errf_edge", 64'(last_errf[0]), 64'(s));
        check("t3.other", 64'((n_valid[0] - v0) + (n_errd[0] - d0)), 64'd0);
        check("t3.busy_recover", out_busy(0), 64'd1);
        idle(0, 2);
        #1;
        check("t3.busy_idle", out_busy(0), 64'd0);
        check("t3.no_restart", 64'(n_errf[0] - f0 + n_errd[0] - d0), 64'd1);
        fill_random(8);
        run_packet(0, -1, 8'($urandom), "t3_after");

        // Gap timeout after four data frames
        d0 = n_errd[0]; v0 = n_valid[0];
        fill_random(4);
        for (int i = 0; i < 4; i++) send_frame(0, 1'b0, pkt_bytes[i], 1'b1, k, s);
        idle(0, GAP + 2);
        #1;
        check("t4.errd_cnt", 64'(n_errd[0] - d0), 64'd1);
        check("t4.errd_edge", 64'(last_errd[0]), 64'(s + GAP));
        check("t4.valid_cnt", 64'(n_valid[0] - v0), 64'd0);
        check("t4.busy", out_busy(0), 64'd0);
        fill_random(8);
        run_packet(0, GAP - 1, 8'($urandom), "t4_maxgap");

        // Reset in the middle of the fifth data frame
        v0 = n_valid[0]; d0 = n_errd[0]; f0 = n_errf[0];
        fill_random(5);
        for (int i = 0; i < 4; i++) send_frame(0, 1'b0, pkt_bytes[i], 1'b1, k, s);
        send_bit(0, 1'b0, k);
        send_bit(0, 1'b0, k);
        for (int i = 7; i >= 5; i--) send_bit(0, pkt_bytes[4][i], k);
        @(negedge clk);
        rst = 1'b1;
        bus32.sin = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("t5.a", out_a(0), 64'd0);
        check("t5.b", out_b(0), 64'd0);
        check("t5.ctl", out_c(0), 64'd0);
        check("t5.busy", out_busy(0), 64'd0);
        rst = 1'b0;
        exp_a = '{64'd0, 64'd0};
        exp_b = '{64'd0, 64'd0};
        exp_c = '{64'd0, 64'd0};
        idle(0, 3);
        #1;
        check("t5.no_pulse", 64'((n_valid[0] - v0) + (n_errd[0] - d0) + (n_errf[0] - f0)), 64'd0);
        fill_random(8);
        run_packet(0, -1, 8'($urandom), "t5_after");

        pkt_bytes = '{8'hBE, 8'hEF, 8'hCA, 8'hFE};
        run_packet(1, 0, 8'h3C, "t6_w16");
        check("t6.a_const", out_a(1), 64'hCAFE);
        check("t6.b_const", out_b(1), 64'hBEEF);
        for (int i = 0; i < 3; i++) begin
            fill_random(4);
            run_packet(1, -1, 8'($urandom), "rnd16");
        end
        fill_random(9);
        run_packet(0, -1, 8'($urandom), "t6_nine");
        fill_random(8);
        run_packet(0, 0, 8'($urandom), "t6_after");

        check("exclusive", 64'(excl_bad), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
